inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DEPTH, default 2, output buffer entries; power of two, at least 2.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 global_rst  input  1  reset, asynchronous, active-low.
REQ-004 pc  input  32  current fetch address from the program counter.
REQ-005 redirect  input  1  control-flow change; same cycle as the program counter's set_pc.
REQ-006 pc_advance  output  1  one-cycle pulse: the program counter steps to pc+4.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  request address.
REQ-009 imem_gnt  input  1  memory accepts the request this cycle.
REQ-010 imem_rvalid  input  1  response data valid.
REQ-011 imem_rdata  input  32  response instruction word.
REQ-012 if_valid  output  1  an instruction is available to decode.
REQ-013 if_ready  input  1  decode accepts it; a transfer occurs when if_valid and if_ready are both high.
REQ-014 if_inst  output  32  instruction word at the head of the buffer.
REQ-015 if_pc  output  32  address of if_inst.
REQ-016 if_misalign  output  1  head entry is a misaligned-fetch marker.

Function
REQ-017 The block SHALL have at most one memory request outstanding, and a response SHALL arrive no earlier than the cycle after grant.
REQ-018 The FSM SHALL have these states:
- IDLE: imem_req low.
- REQ: imem_req high; imem_addr holds until grant.
- WAIT: granted; waiting for rvalid.
- DROP: granted; the response will be discarded.
REQ-019 IDLE SHALL go to REQ when count < DEPTH and redirect is low; it latches imem_addr = pc and the entry pc.
REQ-020 In REQ, imem_req and imem_addr SHALL stay stable until imem_gnt; requests are never withdrawn.
REQ-021 A redirect in REQ (before or with grant) SHALL set a kill flag; a grant with kill set SHALL go to DROP, otherwise to WAIT.
REQ-022 pc_advance SHALL equal imem_gnt and REQ state and not kill and not redirect.
REQ-023 WAIT with rvalid SHALL push {imem_rdata, latched pc, misalign=0}, then go to REQ if count after the push is < DEPTH, otherwise to IDLE.
REQ-024 WAIT with redirect SHALL go to DROP; a simultaneous rvalid is discarded.
REQ-025 DROP with rvalid SHALL discard the data and go to IDLE, clearing kill.
REQ-026 Latency SHALL be one cycle: rvalid at cycle n gives if_valid at n+1; there is no bypass path.
REQ-027 The buffer SHALL be a FIFO with wrapping pointers; push and pop in the same cycle leave count unchanged.
REQ-028 if_inst, if_pc and if_misalign SHALL stay stable while if_valid is high and if_ready is low.
REQ-029 Redirect SHALL empty the buffer at the next edge and override any push or pop in the same cycle; if_valid is low the following cycle.
REQ-030 rvalid in IDLE or REQ SHALL be ignored.

Reset
REQ-031 Asserting global_rst SHALL immediately force state IDLE, buffer empty, kill cleared, and imem_req, pc_advance, if_valid and if_misalign low.
REQ-032 After reset, a stale rvalid SHALL be ignored and the first request SHALL use the pc presented after release.

Configuration
REQ-033 With IFETCH_MISALIGN_CHECK_EN defined, IDLE with pc[1:0] != 0 and space available SHALL NOT request memory:
- it pushes {0x00000000, pc, misalign=1} with no pc_advance;
- it then stays in IDLE, issuing nothing, until redirect.
REQ-034 Without IFETCH_MISALIGN_CHECK_EN, if_misalign SHALL be tied low and pc SHALL be issued unmodified.

Verification
REQ-035 Reset release, pc=0x80000000, gnt same cycle, rvalid 1 cycle later with 0x00000413, if_ready high -> if_valid one cycle after rvalid with if_pc=0x80000000 and if_inst=0x00000413; one pc_advance pulse.
REQ-036 if_ready low, 3 back-to-back fetches -> 2 entries buffered, imem_req stays low, if_inst stable; raise if_ready -> fetching resumes in order.
REQ-037 Redirect in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data never reaches if_inst; next request uses the new pc; buffer empty after redirect.
REQ-038 Redirect coincident with imem_gnt -> pc_advance low, DROP entered, response discarded.
REQ-039 global_rst asserted in WAIT, rvalid during reset and on the first cycle after release -> no push; if_valid low.
REQ-040 With IFETCH_MISALIGN_CHECK_EN defined, pc=0x80000002 -> no imem_req; if_misalign=1 with if_pc=0x80000002; stalled until redirect.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction fetch bus bundle: the memory request/response channel and the
// fetch-to-decode channel. The fetch unit uses the master modport; the
// memory/decode side uses the slave modport.
interface inst_fetch_if;
  // Instruction memory channel
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  // Decode channel
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_misalign;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_inst, if_pc, if_misalign,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_inst, if_pc, if_misalign,
    output if_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one outstanding instruction memory request at
// a time, buffers responses in a DEPTH-entry FIFO and presents the head entry
// to decode with a valid/ready handshake. A redirect kills the in-flight
// response and flushes the buffer.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN -- a misaligned pc is not
// fetched; a misaligned-fetch marker entry is queued instead and fetching
// stalls until the next redirect.
module inst_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        global_rst,
  input  logic [31:0] pc,
  input  logic        redirect,
  output logic        pc_advance,
  inst_fetch_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state_reg;
  logic          kill_reg;
  logic          req_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   entry_pc_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic          space;
  logic          pop;
  logic          push_fetch;
  logic          push;
  logic          idle_go;
  logic          mis_trap;
  logic [31:0]   push_inst;
  logic [31:0]   push_pc;
  logic [CW-1:0] count_next;

  assign space      = (count_reg < DEPTH_C);
  // A redirect flushes the buffer, so it overrides any pop or push.
  assign pop        = (count_reg != '0) && bus.if_ready && !redirect;
  assign push_fetch = (state_reg == WAIT) && bus.imem_rvalid && !redirect;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic stall_reg;
  logic mis_mem [DEPTH];

  assign idle_go  = (state_reg == IDLE) && !redirect && space && !stall_reg
                    && (pc[1:0] == 2'b00);
  assign mis_trap = (state_reg == IDLE) && !redirect && space && !stall_reg
                    && (pc[1:0] != 2'b00);

  // After a misaligned marker is queued, nothing is issued until a redirect.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst)   stall_reg <= 1'b0;
    else if (redirect) stall_reg <= 1'b0;
    else if (mis_trap) stall_reg <= 1'b1;
  end
`else
  assign idle_go  = (state_reg == IDLE) && !redirect && space;
  assign mis_trap = 1'b0;
`endif

  assign push       = push_fetch || mis_trap;
  assign push_inst  = mis_trap ? 32'h0000_0000 : bus.imem_rdata;
  assign push_pc    = mis_trap ? pc : entry_pc_reg;
  assign count_next = count_reg + CW'(push) - CW'(pop);

  // The program counter steps in the cycle the memory accepts a live request.
  assign pc_advance = bus.imem_gnt && (state_reg == REQ) && !kill_reg && !redirect;

  // Fetch FSM: request issue, grant tracking and response kill handling.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      state_reg    <= IDLE;
      kill_reg     <= 1'b0;
      req_reg      <= 1'b0;
      addr_reg     <= '0;
      entry_pc_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (idle_go) begin
            state_reg    <= REQ;
            req_reg      <= 1'b1;
            addr_reg     <= pc;
            entry_pc_reg <= pc;
            kill_reg     <= 1'b0;
          end
        end
        REQ: begin
          // The request is never withdrawn; a redirect only marks it dead.
          kill_reg <= kill_reg || redirect;
          if (bus.imem_gnt) begin
            req_reg   <= 1'b0;
            state_reg <= (kill_reg || redirect) ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            state_reg <= DROP;
          end else if (bus.imem_rvalid) begin
            if (count_next < DEPTH_C) begin
              state_reg    <= REQ;
              req_reg      <= 1'b1;
              addr_reg     <= pc;
              entry_pc_reg <= pc;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        DROP: begin
          if (bus.imem_rvalid) begin
            state_reg <= IDLE;
            kill_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
          kill_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Per-entry storage; contents need no reset because if_valid gates them.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture the pushed entry into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PW'(gi))) begin
        inst_mem[gi] <= push_inst;
        pc_mem[gi]   <= push_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
        mis_mem[gi]  <= mis_trap;
`endif
      end
    end
  end

  assign bus.imem_req  = req_reg;
  assign bus.imem_addr = addr_reg;
  assign bus.if_valid  = (count_reg != '0);
  assign bus.if_inst   = inst_mem[rd_ptr_reg];
  assign bus.if_pc     = pc_mem[rd_ptr_reg];
`ifdef IFETCH_MISALIGN_CHECK_EN
  assign bus.if_misalign = (count_reg != '0) && mis_mem[rd_ptr_reg];
`else
  assign bus.if_misalign = 1'b0;
`endif

endmodule
